// File: rtl/pu_riscv_mul_pipe_if.sv
// rtl/pu_riscv_mul_pipe_if.sv - issue/result handshake bundle for the execute-stage multiplier
//  in_*  : op issue channel (valid/ready), raw instruction, tag, rs1/rs2 values
//  out_* : result channel (valid/ready), result, tag, illegal-op flag
//  master: core/issue side; slave: multiplier side
interface pu_riscv_mul_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  opA;
  logic [XLEN-1:0]  opB;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_tag, opA, opB, out_ready,
    input  in_ready, out_valid, out_r, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_tag, opA, opB, out_ready,
    output in_ready, out_valid, out_r, out_tag, out_illegal
  );
endinterface

// File: rtl/pu_riscv_mul_pipe.sv
// rtl/pu_riscv_mul_pipe.sv - pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW)
//  clk, rstn : clock, asynchronous active-low reset
//  flush     : synchronous kill of every in-flight op (and of any accept this cycle)
//  st_xlen   : current XLEN mode, sampled with the op at acceptance
//  bus       : slave side of pu_riscv_mul_pipe_if (issue and result channels)
//  The product is formed in front of slot 0; slots 1..STAGES-1 only carry the
//  result so accept-to-result latency is STAGES cycles with bubble collapsing.
module pu_riscv_mul_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic [1:0] st_xlen,
  pu_riscv_mul_pipe_if.slave bus
);
  localparam logic [1:0] RV32I = 2'b01;
  localparam int         LAST  = STAGES - 1;

  // ---------------- decode ----------------
  logic [6:0] func7;
  logic [4:0] opc;
  logic [2:0] func3;
  logic       is_mul;
  logic       is_mulw;
  logic       signed_a;
  logic       signed_b;
  logic       unused_instr_bits;

  assign func7   = bus.in_instr[31:25];
  assign opc     = bus.in_instr[6:2];
  assign func3   = bus.in_instr[14:12];
  assign is_mul  = (func7 == 7'b0000001) && (opc == 5'b01100) && !func3[2];
  assign is_mulw = (func7 == 7'b0000001) && (opc == 5'b01110) && (func3 == 3'b000) &&
                   (XLEN == 64) && (st_xlen != RV32I);

  // MULHU is the only fully unsigned form; MULHSU keeps rs1 signed
  assign signed_a = is_mulw | (func3 != 3'b011);
  assign signed_b = is_mulw | !func3[1];

  assign unused_instr_bits = ^{bus.in_instr[24:15], bus.in_instr[11:7], bus.in_instr[1:0]};

  // ---------------- arithmetic ----------------
  logic [XLEN-1:0]   a_w, b_w, a_x, b_x, a_abs, b_abs;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] prod_u, prod;
  logic [XLEN-1:0]   res;

  always_comb begin
    a_w    = XLEN'($signed(bus.opA[31:0]));
    b_w    = XLEN'($signed(bus.opB[31:0]));
    a_x    = is_mulw ? a_w : bus.opA;
    b_x    = is_mulw ? b_w : bus.opB;
    a_neg  = signed_a & a_x[XLEN-1];
    b_neg  = signed_b & b_x[XLEN-1];
    a_abs  = a_neg ? -a_x : a_x;
    b_abs  = b_neg ? -b_x : b_x;
    prod_u = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
    // negating a zero product wraps back to zero
    prod   = (a_neg ^ b_neg) ? -prod_u : prod_u;
    res    = '0;
    if (is_mulw)
      res = XLEN'($signed(prod[31:0]));
    else if (is_mul)
      res = (func3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---------------- pipeline slots ----------------
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ill_q;
  logic [XLEN-1:0]   r_q   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;
  logic [XLEN-1:0]   nxt_r   [STAGES];
  logic [TAG_W-1:0]  nxt_tag [STAGES];
  logic [STAGES-1:0] nxt_ill;
  logic              rdy;
  logic              accept;

  // A full slot advances when the output drains or any later slot is empty:
  // every occupied slot between it and that hole moves up together.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = v_q[i] & bus.out_ready;
      for (int j = i + 1; j < STAGES; j++)
        if (!v_q[j]) adv[i] = v_q[i];
    end
  end

  assign rdy    = !flush & (!v_q[0] | adv[0]);
  assign accept = bus.in_valid & rdy;

  always_comb begin
    ld[0]      = accept;
    nxt_r[0]   = res;
    nxt_tag[0] = bus.in_tag;
    nxt_ill[0] = !(is_mul | is_mulw);
    for (int i = 1; i < STAGES; i++) begin
      ld[i]      = adv[i-1] & !flush;
      nxt_r[i]   = r_q[i-1];
      nxt_tag[i] = tag_q[i-1];
      nxt_ill[i] = ill_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush)       v_q[i] <= 1'b0;
        else if (ld[i])  v_q[i] <= 1'b1;
        else if (adv[i]) v_q[i] <= 1'b0;
        // payload only moves on a load, so a stalled output slot holds its value
        if (ld[i]) begin
          r_q[i]   <= nxt_r[i];
          tag_q[i] <= nxt_tag[i];
          ill_q[i] <= nxt_ill[i];
        end
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = v_q[LAST];
  assign bus.out_r       = r_q[LAST];
  assign bus.out_tag     = tag_q[LAST];
  assign bus.out_illegal = ill_q[LAST];
endmodule

// File: tb/tb_pu_riscv_mul_pipe.sv
// tb/tb_pu_riscv_mul_pipe.sv - self-checking bench for pu_riscv_mul_pipe (STAGES 1..4, main checks on STAGES=3)
module tb_pu_riscv_mul_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam int MAIN  = 2;  // index of the STAGES=3 instance
  localparam logic [1:0]  RV32I    = 2'b01;
  localparam logic [1:0]  RV64I    = 2'b10;
  localparam logic [31:0] I_MUL    = 32'h0200_0033;
  localparam logic [31:0] I_MULH   = 32'h0200_1033;
  localparam logic [31:0] I_MULHSU = 32'h0200_2033;
  localparam logic [31:0] I_MULHU  = 32'h0200_3033;
  localparam logic [31:0] I_MULW   = 32'h0200_003B;
  localparam logic [31:0] I_DIV    = 32'h0200_4033;
  localparam logic [31:0] I_ADD    = 32'h0000_0033;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, out_ready;
  logic [1:0]       st_xlen;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  opA, opB;

  logic [3:0]       ov, ir, oil;
  logic [XLEN-1:0]  orr [4];
  logic [TAG_W-1:0] ot  [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    pu_riscv_mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_instr  = in_instr;
    assign bus.in_tag    = in_tag;
    assign bus.opA       = opA;
    assign bus.opB       = opB;
    assign bus.out_ready = out_ready;
    assign ov[k]  = bus.out_valid;
    assign ir[k]  = bus.in_ready;
    assign oil[k] = bus.out_illegal;
    assign orr[k] = bus.out_r;
    assign ot[k]  = bus.out_tag;
    pu_riscv_mul_pipe #(.XLEN(XLEN), .STAGES(k + 1), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .st_xlen(st_xlen), .bus(bus)
    );
  end

  typedef struct { logic [XLEN-1:0] r; logic [TAG_W-1:0] tag; logic ill; } exp_t;
  typedef struct { logic [31:0] ins; logic [1:0] sx; logic [63:0] a, b, r; logic ill; } vec_t;

  int   n_tests = 0, n_fail = 0;
  exp_t q[$];
  bit   last_acc, last_xfer;
  bit   t3_en = 0;
  int   t3_cyc;
  int   t3_first [4];
  int   t3_seen  [4];
  vec_t vt [17];
  int   lat, tg, cnt;
  bit   held;
  logic [XLEN-1:0]  hr;
  logic [TAG_W-1:0] ht;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // 128-bit reference: sign/zero-extend operands and multiply modulo 2^128
  function automatic exp_t model(input logic [31:0] ins, input logic [1:0] sx,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [127:0] sa, sbv, ua, ub, p;
    logic [63:0]  a32, b32;
    sa  = {{64{a[63]}}, a};
    sbv = {{64{b[63]}}, b};
    ua  = {64'd0, a};
    ub  = {64'd0, b};
    a32 = {{32{a[31]}}, a[31:0]};
    b32 = {{32{b[31]}}, b[31:0]};
    e.tag = tag;
    e.ill = 1'b0;
    e.r   = '0;
    if (ins[31:25] == 7'b0000001 && ins[6:2] == 5'b01100 && ins[14] == 1'b0) begin
      case (ins[13:12])
        2'd0:    begin p = ua * ub;  e.r = p[63:0];   end
        2'd1:    begin p = sa * sbv; e.r = p[127:64]; end
        2'd2:    begin p = sa * ub;  e.r = p[127:64]; end
        default: begin p = ua * ub;  e.r = p[127:64]; end
      endcase
    end else if (ins[31:25] == 7'b0000001 && ins[6:2] == 5'b01110 && ins[14:12] == 3'b000 && sx != RV32I) begin
      p   = {{64{a32[63]}}, a32} * {{64{b32[63]}}, b32};
      e.r = {{32{p[31]}}, p[31:0]};
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One cycle: inputs were set at a negedge; sample 1 unit later, score, move to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    last_acc  = in_valid && ir[MAIN];
    last_xfer = ov[MAIN] && out_ready && !flush;
    if (flush) q.delete();
    else begin
      if (last_xfer) begin
        if (q.size() == 0) chk("sb_unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_r", orr[MAIN], e.r);
          chk("sb_tag", ot[MAIN], e.tag);
          chk("sb_ill", oil[MAIN], e.ill);
        end
      end
      if (last_acc) q.push_back(model(in_instr, st_xlen, opA, opB, in_tag));
    end
    if (t3_en) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k]) begin
          if (t3_first[k] < 0) t3_first[k] = t3_cyc;
          chk($sformatf("t3_tag_order_s%0d", k + 1), ot[k], 64'(t3_seen[k]));
          chk($sformatf("t3_consecutive_s%0d", k + 1), 64'(t3_cyc), 64'(t3_first[k] + t3_seen[k]));
          t3_seen[k]++;
        end
      end
      t3_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] ins, input logic [1:0] sx, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_instr = ins; st_xlen = sx; opA = a; opB = b; in_tag = tag;
  endtask

  // Issue one op into an empty pipe with out_ready=1 and check latency and result.
  task automatic issue_check(input string name, input logic [31:0] ins, input logic [1:0] sx,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [TAG_W-1:0] tag, input logic [63:0] r, input logic ill);
    set_op(ins, sx, a, b, tag);
    tick();
    chk({name, "_accept"}, last_acc, 1);
    in_valid = 1'b0;
    lat = 0;
    while (!ov[MAIN] && lat < 10) begin tick(); lat++; end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_r"}, orr[MAIN], r);
    chk({name, "_illegal"}, oil[MAIN], ill);
    chk({name, "_tag"}, ot[MAIN], tag);
    tick();
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'($urandom), 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] base;
    case ($urandom_range(0, 6))
      0:       base = I_MUL;
      1:       base = I_MULH;
      2:       base = I_MULHSU;
      3:       base = I_MULHU;
      4, 5:    base = I_MULW;
      default: base = ($urandom_range(0, 1) != 0) ? I_DIV : I_ADD;
    endcase
    return base | (32'($urandom) & 32'h01FF_8F80);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{I_MUL,    RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[1]  = '{I_MULH,   RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b0};
    vt[2]  = '{I_MULHSU, RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[3]  = '{I_MULHU,  RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[4]  = '{I_MULW,   RV64I, 64'h0000_0000_7FFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[5]  = '{I_MULW,   RV32I, 64'h0000_0000_7FFF_FFFF, 64'd2,                  64'd0,                  1'b1};
    vt[6]  = '{I_MULH,   RV64I, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vt[7]  = '{I_MULH,   RV64I, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b0};
    vt[8]  = '{I_MULHU,  RV64I, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1,                  1'b0};
    vt[9]  = '{I_MULW,   RV64I, 64'h1234_5678_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vt[10] = '{I_MULHSU, RV64I, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0};
    vt[11] = '{I_MUL,    RV64I, 64'h1234,               64'h10,                 64'h12340,              1'b0};
    vt[12] = '{I_DIV,    RV64I, 64'd6,                  64'd3,                  64'd0,                  1'b1};
    vt[13] = '{I_ADD,    RV64I, 64'd6,                  64'd3,                  64'd0,                  1'b1};
    vt[14] = '{I_MUL,    RV64I, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                  64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
    vt[15] = '{I_MULH,   RV64I, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[16] = '{I_MULH,   RV64I, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    st_xlen = RV64I; in_instr = '0; in_tag = '0; opA = '0; opB = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov[MAIN], 0);
    chk("rst_out_r", orr[MAIN], 0);
    chk("rst_out_tag", ot[MAIN], 0);
    chk("rst_out_illegal", oil[MAIN], 0);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", ir[MAIN], 1);
    @(negedge clk);

    // T1/T2 and boundary vectors
    for (int i = 0; i < 17; i++)
      issue_check($sformatf("vec%0d", i), vt[i].ins, vt[i].sx, vt[i].a, vt[i].b, TAG_W'(i), vt[i].r, vt[i].ill);

    // T4 backpressure
    out_ready = 1'b0; tg = 16; held = 0;
    for (int c = 0; c < 10; c++) begin
      set_op(I_MUL, RV64I, 64'(tg), 64'd7, TAG_W'(tg));
      tick();
      if (last_acc) tg++;
      if (ov[MAIN]) begin
        if (!held) begin held = 1; hr = orr[MAIN]; ht = ot[MAIN]; end
        else begin
          chk("bp_hold_r", orr[MAIN], hr);
          chk("bp_hold_tag", ot[MAIN], ht);
        end
      end
    end
    chk("bp_accepts", 64'(tg - 16), 3);
    chk("bp_in_ready_low", ir[MAIN], 0);
    chk("bp_out_valid_seen", held, 1);
    in_valid = 1'b0; out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (last_xfer) cnt++; end
    chk("bp_drained", 64'(cnt), 3);
    chk("bp_queue_empty", 64'(q.size()), 0);

    // T5 flush with 3 ops in flight and an op presented on the flush edge
    out_ready = 1'b0; cnt = 0;
    for (int c = 0; c < 3; c++) begin
      set_op(I_MULHU, RV64I, 64'(c + 1), 64'd9, TAG_W'(20 + c));
      tick();
      if (last_acc) cnt++;
    end
    chk("fl_accepts", 64'(cnt), 3);
    set_op(I_MUL, RV64I, 64'd5, 64'd5, TAG_W'(23));
    flush = 1'b1;
    tick();
    chk("fl_no_accept", last_acc, 0);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", ov[MAIN], 0);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 6; c++) begin if (ov[MAIN]) cnt++; tick(); end
    chk("fl_no_stale", 64'(cnt), 0);
    issue_check("fl_next", I_MULHU, RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, TAG_W'(24), 64'd1, 1'b0);

    // T3 back-to-back, all depths
    flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
    for (int k = 0; k < 4; k++) begin t3_first[k] = -1; t3_seen[k] = 0; end
    t3_cyc = 0; t3_en = 1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) set_op(I_MUL, RV64I, 64'(c), 64'd3, TAG_W'(c));
      else in_valid = 1'b0;
      tick();
    end
    t3_en = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_first_latency_s%0d", k + 1), 64'(t3_first[k]), 64'(k + 1));
      chk($sformatf("t3_count_s%0d", k + 1), 64'(t3_seen[k]), 8);
    end

    // T6 asynchronous reset mid-stream
    for (int c = 0; c < 4; c++) begin
      set_op(I_MULH, RV64I, 64'hFFFF_FFFF_FFFF_FFFF, 64'(c + 2), TAG_W'(c + 1));
      tick();
    end
    chk("rs_pre_valid", ov[MAIN], 1);
    #2 rstn = 1'b0;
    #1;
    chk("rs_async_valid", ov[MAIN], 0);
    chk("rs_async_r", orr[MAIN], 0);
    chk("rs_async_tag", ot[MAIN], 0);
    chk("rs_async_illegal", oil[MAIN], 0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rs_in_ready", ir[MAIN], 1);
    @(negedge clk);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin if (ov[MAIN]) cnt++; tick(); end
    chk("rs_no_stale", 64'(cnt), 0);

    // random run scored by the reference model
    for (int c = 0; c < 400; c++) begin
      set_op(rnd_op(), ($urandom_range(0, 3) == 0) ? RV32I : RV64I, rnd64(), rnd64(), TAG_W'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("rand_drain_empty", 64'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
